// File: rtl/l1c_arb_pkg.sv
// l1c_arb_pkg: shared state/owner types and line geometry constants for the L1 memory arbiter
package l1c_arb_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_e;
  localparam int BEAT_BITS = 2;
  localparam int LINE_OFS_BITS = 4;
endpackage

// File: rtl/l1c_arb_pick.sv
// l1c_arb_pick: chooses the next owner from the two cache requests
// Ports: d_req_i/i_req_i pending requests, last_owner_i most recently served, owner_o winner.
// Config: ARB_RR_EN makes ties alternate; otherwise D always wins a tie.
module l1c_arb_pick
  import l1c_arb_pkg::*;
(
  input  logic   d_req_i,
  input  logic   i_req_i,
  input  owner_e last_owner_i,
  output owner_e owner_o
);
  owner_e solo;
  // With no request the result is never latched, so last_owner_i is a harmless filler.
  assign solo = d_req_i ? OWN_D : (i_req_i ? OWN_I : last_owner_i);
`ifdef ARB_RR_EN
  assign owner_o = (d_req_i && i_req_i) ? owner_e'(~last_owner_i) : solo;
`else
  assign owner_o = solo;
`endif
endmodule

// File: rtl/l1c_mem_arbiter.sv
// l1c_mem_arbiter: shares one memory port between D-cache (refill/write-through) and I-cache (refill)
// Ports: clk_i, rst_ni (async active-low); d_* D-cache request/response; i_* I-cache request/response;
//        mem_* memory request (out) and response (mem_rdata_i, mem_wait_i).
// Config: define ARB_RR_EN for round-robin tie-breaking (adds the last_owner register).
module l1c_mem_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 d_req_i,
  input  logic                 d_write_i,
  input  logic [ADDR_BITS-1:0] d_addr_i,
  input  logic [31:0]          d_wdata_i,
  input  logic [3:0]           d_wstrb_i,
  output logic [31:0]          d_rdata_o,
  output logic                 d_wait_o,
  input  logic                 i_req_i,
  input  logic [ADDR_BITS-1:0] i_addr_i,
  output logic [31:0]          i_rdata_o,
  output logic                 i_wait_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_wstrb_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_wait_i
);
  state_e                 state_q, state_d;
  owner_e                 owner_q, pick, last_owner;
  logic                   write_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic [BEAT_BITS-1:0]   beat_q;
  logic                   busy, start, last_beat, d_own, i_own;
  assign busy      = state_q == S_BUSY;
  assign start     = (state_q == S_IDLE) && (d_req_i || i_req_i);
  assign last_beat = busy && !mem_wait_i && (write_q || beat_q == BEAT_BITS'(BURST_LEN - 1));
`ifdef ARB_RR_EN
  owner_e last_owner_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_owner_q <= OWN_I;
    else if (last_beat) last_owner_q <= owner_q;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_I;
`endif
  l1c_arb_pick u_pick (
    .d_req_i      (d_req_i),
    .i_req_i      (i_req_i),
    .last_owner_i (last_owner),
    .owner_o      (pick)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= S_IDLE;
    else state_q <= state_d;
  // DONE always falls back to IDLE, so a held request is arbitrated afresh.
  always_comb state_d = busy ? (last_beat ? S_DONE : S_BUSY) : (start ? S_BUSY : S_IDLE);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      owner_q <= OWN_D;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      beat_q  <= '0;
    end else begin
      if (start) begin
        owner_q <= pick;
        write_q <= (pick == OWN_D) && d_write_i;
        addr_q  <= (pick == OWN_D) ? d_addr_i : i_addr_i;
        wdata_q <= d_wdata_i;
        wstrb_q <= d_wstrb_i;
      end
      if (busy && !mem_wait_i) beat_q <= last_beat ? '0 : beat_q + 1'b1;
    end
  always_comb begin
    d_own       = busy && owner_q == OWN_D;
    i_own       = busy && owner_q == OWN_I;
    mem_req_o   = busy;
    mem_write_o = busy && write_q;
    mem_addr_o  = write_q ? addr_q : {addr_q[ADDR_BITS-1:LINE_OFS_BITS], beat_q, 2'b00};
    mem_wdata_o = wdata_q;
    mem_wstrb_o = wstrb_q;
    d_rdata_o   = d_own ? mem_rdata_i : '0;
    d_wait_o    = d_own ? mem_wait_i : 1'b1;
    i_rdata_o   = i_own ? mem_rdata_i : '0;
    i_wait_o    = i_own ? mem_wait_i : 1'b1;
  end
endmodule

// File: doc/l1c_mem_arbiter.md
L1C_MEM_ARBITER -- requirements
Module: l1c_mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, is the number of 32-bit beats per line refill (128-bit line).
REQ-002 Parameter ADDR_BITS, default 32, is the byte address width on all ports.
REQ-003 clk  in  1  Single clock; all state changes on its rising edge.
REQ-004 rst  in  1  Reset: asynchronous, active-low.
REQ-005 d_req, d_write  in  1 each  D-cache request and write qualifier (0 = line refill, 1 = single-word write-through).
REQ-006 d_addr, d_wdata  in  32 each, plus d_wstrb  in  4  D-cache address, write data and byte strobes.
REQ-007 d_rdata  out  32, d_wait  out  1  Refill beat data to the D-cache; d_wait=0 marks a valid beat or write completion.
REQ-008 i_req  in  1, i_addr  in  32  I-cache refill request and address (I-cache never writes).
REQ-009 i_rdata  out  32, i_wait  out  1  Refill beat data to the I-cache, with the same beat meaning as d_wait.
REQ-010 mem_req, mem_write  out  1 each, plus mem_addr, mem_wdata  out  32 each, plus mem_wstrb  out  4  Memory-side request.
REQ-011 mem_rdata  in  32, mem_wait  in  1  Memory response; mem_wait=0 accepts a write or returns one read beat.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE, held in a 2-bit encoded register.
REQ-013 In IDLE with any request pending, the arbiter SHALL latch owner, write flag, address, wdata and wstrb, then enter BUSY on the next edge.
REQ-014 mem_req SHALL be 1 only in BUSY, so first issue comes one cycle after the request is sampled.
REQ-015 For reads, mem_addr SHALL be {addr[31:4], beat_cnt, 2'b00}, where beat_cnt is 2 bits, starts at 0 and increments on each mem_wait=0 cycle.
REQ-016 For writes, mem_addr SHALL be the latched address unmodified, with mem_wdata and mem_wstrb taken from the latch.
REQ-017 The owner's x_rdata SHALL equal mem_rdata, and its x_wait SHALL equal mem_wait, while in BUSY.
REQ-018 A non-owner's x_wait SHALL be 1, and its x_rdata SHALL be 0.
REQ-019 In IDLE and DONE, both d_wait and i_wait SHALL be 1.
REQ-020 BUSY SHALL end after beat BURST_LEN-1 for a read, or after the first mem_wait=0 for a write, then go to DONE.
REQ-021 The grant SHALL NOT change mid-burst, even if the other requester asserts.
REQ-022 DONE SHALL last exactly one cycle with mem_req=0, then return to IDLE.
REQ-023 DONE exists so the requester can drop x_req, and a held x_req SHALL be re-arbitrated as a new transaction.
REQ-024 A requester dropping x_req during BUSY SHALL be ignored, and the burst SHALL complete.
REQ-025 beat_cnt wrap from 3 to 0 SHALL coincide with leaving BUSY, and no fifth beat SHALL ever be addressed.
REQ-026 When both requests are sampled in IDLE on the same cycle, the winner SHALL follow REQ-031 or REQ-032.

Reset
REQ-027 Asserting rst low SHALL immediately force: state IDLE; mem_req, mem_write and beat_cnt 0; d_wait and i_wait 1; rdata 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further beats forwarded.
REQ-029 On reset, last_owner SHALL be set to I, so that D wins the first tie.
REQ-030 Deassertion SHALL take effect on the first rising edge after rst goes high.

Configuration
REQ-031 With ARB_RR_EN defined, ties SHALL go to the requester not served most recently, with last_owner updated on entry to DONE.
REQ-032 Without ARB_RR_EN, D SHALL always win ties and the last_owner register SHALL be absent.

Structure
REQ-033 Package l1c_arb_pkg SHALL hold the state enum, the owner enum (OWN_D, OWN_I) and the constants BEAT_BITS=2 and LINE_OFS_BITS=4.
REQ-034 Tie-break logic SHALL live in sub-module l1c_arb_pick (inputs d_req, i_req, last_owner; output owner), instantiated once.

Verification
REQ-035 D refill only: d_req=1, d_addr=0x104, mem_wait random → mem_addr 0x100,0x104,0x108,0x10C in order; d_wait low exactly 4 cycles carrying each beat.
REQ-036 D write: d_write=1, d_addr=0x23, d_wdata=0xA5, d_wstrb=0b1000 → one memory beat with mem_addr 0x23 and mem_wstrb 0b1000; d_wait low once; then DONE.
REQ-037 Simultaneous d_req and i_req in IDLE, ARB_RR_EN defined → D served first, then I; with both held, grants alternate D,I,D.
REQ-038 Same stimulus as REQ-037 without ARB_RR_EN → D served on every arbitration while d_req is held; I starves.
REQ-039 i_req asserted during beat 2 of a D burst → D burst completes all 4 beats; i_wait stays 1; I granted after DONE.
REQ-040 rst low during beat 1 of a refill → mem_req 0 in the same cycle; beat_cnt 0; the next request restarts at beat 0.
